spawn_scheduler: RTL

SPAWN_SCHEDULER -- requirements
Module: spawn_scheduler

---
 rtl/spawn_scheduler_if.sv | 17 +
 rtl/spawn_scheduler.sv | 75 +++++++
 2 files changed

// File: rtl/spawn_scheduler_if.sv
// spawn_scheduler_if: request/grant bundle between the spawners and the scheduler
//   obs_req, ban_req : level requests from the obstacle and banana spawners
//   obs_gnt, ban_gnt : one-cycle grant pulses
//   lane             : granted lane code, 3'b000 when no grant is active
//   busy             : scheduler is outside IDLE
//   last_obs_lane    : lane of the most recent obstacle grant
interface spawn_scheduler_if;
    logic       obs_req;
    logic       ban_req;
    logic       obs_gnt;
    logic       ban_gnt;
    logic [2:0] lane;
    logic       busy;
    logic [2:0] last_obs_lane;
    modport master (output obs_req, ban_req, input obs_gnt, ban_gnt, lane, busy, last_obs_lane);
    modport slave  (input obs_req, ban_req, output obs_gnt, ban_gnt, lane, busy, last_obs_lane);
endinterface

// File: rtl/spawn_scheduler.sv
// spawn_scheduler: arbitrates obstacle/banana spawn requests and assigns a pseudo-random lane
//   clk   : rising-edge clock
//   reset : asynchronous active-high reset
//   bus   : spawn_scheduler_if.slave (requests in; grants, lane, busy, last_obs_lane out)
//   Define SPAWN_COLLISION_AVOID_EN to stop a banana from landing on the last obstacle lane.
module spawn_scheduler #(
    parameter logic [2:0] LFSR_SEED = 3'b011,
    parameter int         MIN_GAP   = 4
) (
    input logic clk,
    input logic reset,
    spawn_scheduler_if.slave bus
);
    typedef enum logic [2:0] {IDLE, DRAW, CHECK, GRANT, GAP} state_t;
    state_t     state, state_nx;
    logic [2:0] lfsr, cand, last_obs;
    logic [7:0] gap_cnt;
    logic       ptr, win_ban, pick_ban, retry, any_req;
    assign any_req  = bus.obs_req || bus.ban_req;
    // ptr high means the banana side holds priority on a tie
    assign pick_ban = bus.ban_req && (!bus.obs_req || ptr);
`ifdef SPAWN_COLLISION_AVOID_EN
    assign retry = win_ban && cand == last_obs && last_obs != 3'b000;
`else
    assign retry = 1'b0;
`endif
    always_ff @(posedge clk or posedge reset) begin
        if (reset)
            state <= IDLE;
        else
            state <= state_nx;
    end
    always_comb begin
        state_nx = state;
        case (state)
            IDLE:    state_nx = any_req ? DRAW : IDLE;
            DRAW:    state_nx = CHECK;
            CHECK:   state_nx = retry ? DRAW : GRANT;
            GRANT:   state_nx = GAP;
            GAP:     state_nx = gap_cnt == 8'd0 ? IDLE : GAP;
            default: state_nx = IDLE;
        endcase
    end
    always_comb begin
        bus.obs_gnt       = state == GRANT && !win_ban;
        bus.ban_gnt       = state == GRANT && win_ban;
        bus.lane          = state == GRANT ? cand : 3'b000;
        bus.busy          = state != IDLE;
        bus.last_obs_lane = last_obs;
    end
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            lfsr     <= LFSR_SEED;
            cand     <= 3'b000;
            last_obs <= 3'b000;
            gap_cnt  <= 8'd0;
            ptr      <= 1'b0;
            win_ban  <= 1'b0;
        end else begin
            lfsr <= {lfsr[0] ^ lfsr[1], lfsr[2], lfsr[1]};
            if (state == IDLE && any_req)
                win_ban <= pick_ban;
            if (state == DRAW)
                cand <= lfsr;
            if (state == GRANT) begin
                ptr     <= ~ptr;
                gap_cnt <= 8'(MIN_GAP - 1);
                if (!win_ban)
                    last_obs <= cand;
            end
            if (state == GAP && gap_cnt != 8'd0)
                gap_cnt <= gap_cnt - 8'd1;
        end
    end
endmodule
